// File: rtl/seg7_scan_driver.sv
// ============================================================================
//  Module   : seg7_scan_driver
//  Purpose  : Multiplexed common-anode 7-segment driver with per-digit dp,
//             blank and blink, plus dead time between digit slots.
//             Optional macro LEADING_ZERO_SUPPRESS_EN darkens leading zeros.
//  Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module seg7_scan_driver #(
    parameter int DIGITS       = 8,
    parameter int SCAN_DIV     = 50000,
    parameter int DEAD_CYC     = 2,
    parameter int BLINK_FRAMES = 64
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  load,
    input  logic [4*DIGITS-1:0]   bcd_in,
    input  logic [DIGITS-1:0]     dp_in,
    input  logic [DIGITS-1:0]     blank_in,
    input  logic [DIGITS-1:0]     blink_in,
    output logic [6:0]            seg,
    output logic                  dp,
    output logic [DIGITS-1:0]     an
);

    localparam int CW = $clog2(SCAN_DIV);
    localparam int IW = (DIGITS > 1) ? $clog2(DIGITS) : 1;
    localparam int FW = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;

    localparam logic [CW-1:0]     c_cnt_last   = CW'(SCAN_DIV - 1);
    localparam logic [CW-1:0]     c_dead       = CW'(DEAD_CYC);
    localparam logic [IW-1:0]     c_idx_last   = IW'(DIGITS - 1);
    localparam logic [FW-1:0]     c_frame_last = FW'(BLINK_FRAMES - 1);
    localparam logic [DIGITS-1:0] c_an_one     = DIGITS'(1);

    logic [4*DIGITS-1:0] r_bcd;
    logic [DIGITS-1:0]   r_dp_sh;
    logic [DIGITS-1:0]   r_blank;
    logic [DIGITS-1:0]   r_blink;
    logic [CW-1:0]       r_cnt;
    logic [IW-1:0]       r_idx;
    logic [FW-1:0]       r_frame;
    logic                r_phase;
    logic [6:0]          r_seg;
    logic                r_dp;
    logic [DIGITS-1:0]   r_an;

    logic [3:0]          w_digit [DIGITS];
    logic [DIGITS-1:0]   w_lz;
    logic [6:0]          w_dec;
    logic                w_dark;
    logic [DIGITS-1:0]   w_an_on;

    for (genvar gi = 0; gi < DIGITS; gi++) begin : g_digit
        assign w_digit[gi] = r_bcd[4*gi +: 4];
    end

`ifdef LEADING_ZERO_SUPPRESS_EN
    logic w_run;
    // A digit is suppressed only while every digit from the top down to it is a bare zero.
    always_comb begin
        w_lz  = '0;
        w_run = 1'b1;
        for (int i = DIGITS - 1; i > 0; i--) begin
            w_run   = w_run & (w_digit[i] == 4'd0) & ~r_dp_sh[i];
            w_lz[i] = w_run;
        end
    end
`else
    assign w_lz = '0;
`endif

    always_comb begin
        w_dec = 7'b0110000;
        case (w_digit[r_idx])
            4'd0:    w_dec = 7'b0000001;
            4'd1:    w_dec = 7'b1001111;
            4'd2:    w_dec = 7'b0010010;
            4'd3:    w_dec = 7'b0000110;
            4'd4:    w_dec = 7'b1001100;
            4'd5:    w_dec = 7'b0100100;
            4'd6:    w_dec = 7'b0100000;
            4'd7:    w_dec = 7'b0001111;
            4'd8:    w_dec = 7'b0000000;
            4'd9:    w_dec = 7'b0000100;
            default: w_dec = 7'b0110000;
        endcase
    end

    assign w_dark  = r_blank[r_idx] | (r_blink[r_idx] & r_phase) | w_lz[r_idx];
    assign w_an_on = ~(c_an_one << r_idx);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_bcd   <= '0;
            r_dp_sh <= '0;
            r_blank <= '0;
            r_blink <= '0;
        end else if (load) begin
            r_bcd   <= bcd_in;
            r_dp_sh <= dp_in;
            r_blank <= blank_in;
            r_blink <= blink_in;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_cnt   <= '0;
            r_idx   <= '0;
            r_frame <= '0;
            r_phase <= 1'b0;
        end else if (r_cnt == c_cnt_last) begin
            r_cnt <= '0;
            if (r_idx == c_idx_last) begin
                r_idx <= '0;
                if (r_frame == c_frame_last) begin
                    r_frame <= '0;
                    r_phase <= ~r_phase;
                end else begin
                    r_frame <= r_frame + 1'b1;
                end
            end else begin
                r_idx <= r_idx + 1'b1;
            end
        end else begin
            r_cnt <= r_cnt + 1'b1;
        end
    end

    // Segments change only on slot entry, while the anodes are still dark.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_seg <= 7'h7F;
            r_dp  <= 1'b1;
            r_an  <= '1;
        end else begin
            if (r_cnt == '0) begin
                if (w_dark) begin
                    r_seg <= 7'h7F;
                    r_dp  <= 1'b1;
                end else begin
                    r_seg <= w_dec;
                    r_dp  <= ~r_dp_sh[r_idx];
                end
            end
            r_an <= (r_cnt < c_dead) ? '1 : w_an_on;
        end
    end

    assign seg = r_seg;
    assign dp  = r_dp;
    assign an  = r_an;

endmodule

`default_nettype wire

// File: tb/tb_seg7_scan_driver.sv
// ============================================================================
//  Module   : tb_seg7_scan_driver
//  Purpose  : Randomized self-checking bench for seg7_scan_driver against a
//             slot/frame arithmetic reference model.
//  Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_seg7_scan_driver;

    localparam int DIGITS       = 4;
    localparam int SCAN_DIV     = 8;
    localparam int DEAD_CYC     = 2;
    localparam int BLINK_FRAMES = 2;

    logic                clk = 1'b0;
    logic                rst = 1'b0;
    logic                load = 1'b0;
    logic [4*DIGITS-1:0] bcd_in = '0;
    logic [DIGITS-1:0]   dp_in = '0;
    logic [DIGITS-1:0]   blank_in = '0;
    logic [DIGITS-1:0]   blink_in = '0;
    logic [6:0]          seg;
    logic                dp;
    logic [DIGITS-1:0]   an;

    seg7_scan_driver #(
        .DIGITS       (DIGITS),
        .SCAN_DIV     (SCAN_DIV),
        .DEAD_CYC     (DEAD_CYC),
        .BLINK_FRAMES (BLINK_FRAMES)
    ) u_dut (
        .clk      (clk),
        .rst      (rst),
        .load     (load),
        .bcd_in   (bcd_in),
        .dp_in    (dp_in),
        .blank_in (blank_in),
        .blink_in (blink_in),
        .seg      (seg),
        .dp       (dp),
        .an       (an)
    );

    always #5 clk = ~clk;

    logic [6:0] dec [16] = '{7'b0000001, 7'b1001111, 7'b0010010, 7'b0000110,
                             7'b1001100, 7'b0100100, 7'b0100000, 7'b0001111,
                             7'b0000000, 7'b0000100, 7'b0110000, 7'b0110000,
                             7'b0110000, 7'b0110000, 7'b0110000, 7'b0110000};

    int n_checks = 0;
    int n_bad    = 0;
    int n        = 0;

    logic [3:0]        m_bcd   [DIGITS];
    logic              m_dp    [DIGITS];
    logic              m_blank [DIGITS];
    logic              m_blink [DIGITS];
    logic [6:0]        e_seg = 7'h7F;
    logic              e_dp  = 1'b1;
    logic [DIGITS-1:0] e_an  = '1;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s got=%h exp=%h t=%0t n=%0d", tag, got, exp, $time, n);
        end
    endtask

    function automatic logic [7:0] model_out(int d, int ph);
        bit dark;
        dark = m_blank[d] || (m_blink[d] && ph == 1);
`ifdef LEADING_ZERO_SUPPRESS_EN
        if (d > 0) begin
            bit allz = 1'b1;
            for (int j = d; j < DIGITS; j++)
                if (m_bcd[j] != 4'd0 || m_dp[j]) allz = 1'b0;
            if (allz) dark = 1'b1;
        end
`endif
        if (dark) return {7'h7F, 1'b1};
        return {dec[m_bcd[d]], ~m_dp[d]};
    endfunction

    task automatic model_clear();
        for (int d = 0; d < DIGITS; d++) begin
            m_bcd[d] = '0; m_dp[d] = 1'b0; m_blank[d] = 1'b0; m_blink[d] = 1'b0;
        end
        n = 0; e_seg = 7'h7F; e_dp = 1'b0 | 1'b1; e_an = '1;
    endtask

    // One clock: predict from edge count since reset release, then compare.
    task automatic step();
        int cb, slot, idx, ph;
        cb   = n % SCAN_DIV;
        slot = n / SCAN_DIV;
        idx  = slot % DIGITS;
        ph   = (slot / DIGITS / BLINK_FRAMES) % 2;
        if (cb == 0) {e_seg, e_dp} = model_out(idx, ph);
        e_an = (cb < DEAD_CYC) ? '1 : ~(DIGITS'(1) << idx);
        if (load) begin
            for (int d = 0; d < DIGITS; d++) begin
                m_bcd[d]   = bcd_in[4*d +: 4];
                m_dp[d]    = dp_in[d];
                m_blank[d] = blank_in[d];
                m_blink[d] = blink_in[d];
            end
        end
        @(posedge clk);
        n++;
        #1;
        chk("an", 32'(an), 32'(e_an));
        chk("seg", 32'(seg), 32'(e_seg));
        chk("dp", 32'(dp), 32'(e_dp));
    endtask

    task automatic run(int k);
        for (int i = 0; i < k; i++) step();
    endtask

    task automatic do_load(input logic [15:0] b, input logic [3:0] p,
                           input logic [3:0] bl, input logic [3:0] bk);
        bcd_in = b; dp_in = p; blank_in = bl; blink_in = bk;
        load = 1'b1;
        step();
        load = 1'b0;
    endtask

    initial begin
        model_clear();
        #1 rst = 1'b1;
        #1;
        chk("rst_an", 32'(an), 32'hF);
        chk("rst_seg", 32'(seg), 32'h7F);
        chk("rst_dp", 32'(dp), 32'h1);
        @(posedge clk); @(posedge clk); #1;
        rst = 1'b0;

        run(5);
        do_load(16'h1234, 4'b0000, 4'b0000, 4'b0000);
        run(70);
        do_load(16'h9AF0, 4'b0010, 4'b0000, 4'b0000);
        run(40);
        do_load(16'h9AF0, 4'b0010, 4'b0100, 4'b0001);
        run(300);

        while (n % SCAN_DIV != 3) step();
        do_load(16'h0000, 4'b0000, 4'b0000, 4'b0000);
        run(20);

        while (n % SCAN_DIV != 0) step();
        do_load(16'h0050, 4'b0000, 4'b0000, 4'b0000);
        run(70);

        for (int i = 0; i < 800; i++) begin
            if ($urandom_range(0, 11) == 0)
                do_load(16'($urandom), 4'($urandom), 4'($urandom & $urandom),
                        4'($urandom));
            else
                step();
        end

        // Asynchronous reset in the middle of a slot.
        while (n % SCAN_DIV != 5) step();
        #2 rst = 1'b1;
        #1;
        chk("arst_an", 32'(an), 32'hF);
        chk("arst_seg", 32'(seg), 32'h7F);
        chk("arst_dp", 32'(dp), 32'h1);
        @(posedge clk); #1;
        chk("arst_hold_an", 32'(an), 32'hF);
        model_clear();
        rst = 1'b0;
        run(40);
        do_load(16'h0050, 4'b0000, 4'b0000, 4'b0000);
        run(80);

        $display("test done: total=%0d bad=%0d", n_checks, n_bad);
        $finish;
    end

endmodule

`default_nettype wire
